// File: rtl/tdm_demux_8ch.sv
// Receive side of the 8-channel TDM link: tracks the slot count, collects samples
// into a shadow register and commits each complete 0..7 frame to y in one step.
module tdm_demux_8ch #(
   parameter int WIDTH = 1,
   parameter int NCH   = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [WIDTH-1:0]     din,
   input  logic                 din_valid,
   input  logic                 frame_sync,
   output logic [NCH*WIDTH-1:0] y,
   output logic [NCH-1:0]       ch_strobe,
   output logic                 frame_done,
   output logic                 locked,
   output logic                 sync_err
);

   localparam logic [0:0] HUNT   = 1'b0;
   localparam logic [0:0] LOCKED = 1'b1;

   logic [0:0]           state;
   logic [0:0]           state_next;
   logic [2:0]           slot;
   logic [2:0]           slot_next;
   logic [2:0]           wr_slot;
   logic [NCH*WIDTH-1:0] shadow;
   logic                 take;
   logic                 commit;
   logic                 err;
   logic [NCH-1:0]       strobe_next;

   // Framing decisions for the sample on din. A sync always restarts at slot 0,
   // so an early sync simply overwrites the abandoned partial frame from slot 0 up.
   always_comb begin
      state_next = state;
      slot_next  = slot;
      take       = 1'b0;
      commit     = 1'b0;
      err        = 1'b0;
      wr_slot    = frame_sync ? 3'd0 : slot;
      if (din_valid) begin
         if (state == HUNT) begin
            if (frame_sync) begin
               take       = 1'b1;
               state_next = LOCKED;
               slot_next  = 3'd1;
            end
         end else if (slot == 3'd0 && !frame_sync) begin
            err        = 1'b1;
            state_next = HUNT;
            slot_next  = 3'd0;
         end else begin
            take      = 1'b1;
            err       = (slot != 3'd0) && frame_sync;
            commit    = !frame_sync && (slot == 3'd7);
            slot_next = wr_slot + 3'd1;
         end
      end
   end

   always_comb begin
      strobe_next = '0;
      if (take) begin
         strobe_next[wr_slot] = 1'b1;
      end
   end

   // y is loaded with the final sample merged in directly, so the frame appears
   // on the same edge as ch_strobe[7] rather than one cycle later.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= HUNT;
         slot       <= 3'd0;
         shadow     <= '0;
         y          <= '0;
         ch_strobe  <= '0;
         frame_done <= 1'b0;
         locked     <= 1'b0;
         sync_err   <= 1'b0;
      end else begin
         state      <= state_next;
         slot       <= slot_next;
         locked     <= (state_next == LOCKED);
         ch_strobe  <= strobe_next;
         frame_done <= commit;
         sync_err   <= err;
         if (take) begin
            shadow[wr_slot*WIDTH +: WIDTH] <= din;
         end
         if (commit) begin
            y <= {din, shadow[(NCH-1)*WIDTH-1:0]};
         end
      end
   end

endmodule

// File: tb/tb_tdm_demux_8ch.sv
// Directed bench for tdm_demux_8ch with 4-bit samples; each task drives one
// scenario and compares outputs sampled 1ns after the clock edge.
module tb_tdm_demux_8ch;

   localparam int W   = 4;
   localparam int NCH = 8;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic [W-1:0]     din = '0;
   logic             din_valid = 1'b0;
   logic             frame_sync = 1'b0;
   logic [NCH*W-1:0] y;
   logic [NCH-1:0]   ch_strobe;
   logic             frame_done;
   logic             locked;
   logic             sync_err;
   logic [10:0]      st;
   logic [10:0]      exp_st;

   int total = 0;
   int bad   = 0;

   tdm_demux_8ch #(.WIDTH(W), .NCH(NCH)) dut (
      .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .frame_sync(frame_sync),
      .y(y), .ch_strobe(ch_strobe), .frame_done(frame_done), .locked(locked), .sync_err(sync_err)
   );

   always #5 clk = ~clk;

   // Packed view of the pulse/status outputs: {ch_strobe, frame_done, sync_err, locked}
   assign st = {ch_strobe, frame_done, sync_err, locked};

   task automatic drive(input logic v, input logic fs, input logic [W-1:0] d);
      din_valid  = v;
      frame_sync = fs;
      din        = d;
      @(posedge clk);
      #1;
      din_valid  = 1'b0;
      frame_sync = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      #2;
      total++;
      if ({y, st} !== '0) begin
         bad++;
         $display("[TB] FAIL reset_async y=%h st=%b want all zero", y, st);
      end
      @(posedge clk);
      @(posedge clk);
      #1;
      total++;
      if ({y, st} !== '0) begin
         bad++;
         $display("[TB] FAIL reset_held y=%h st=%b want all zero", y, st);
      end
      rst = 1'b0;
   endtask

   task automatic test_full_frame();
      for (int k = 0; k < 8; k++) begin
         drive(1'b1, k == 0, W'(k));
         exp_st = {8'h01 << k, (k == 7), 1'b0, 1'b1};
         total++;
         if (st !== exp_st) begin
            bad++;
            $display("[TB] FAIL full_frame slot%0d st=%b want %b", k, st, exp_st);
         end
      end
      total++;
      if (y !== 32'h76543210) begin
         bad++;
         $display("[TB] FAIL full_frame_y y=%h want 76543210", y);
      end
      drive(1'b0, 1'b0, 4'h0);
      total++;
      if ({y, st} !== {32'h76543210, 8'h00, 1'b0, 1'b0, 1'b1}) begin
         bad++;
         $display("[TB] FAIL full_frame_idle y=%h st=%b", y, st);
      end
   endtask

   task automatic test_valid_toggle();
      for (int i = 0; i < 16; i++) begin
         if (i % 2 == 0) begin
            drive(1'b1, i == 0, W'(i / 2));
            exp_st = {8'h01 << (i / 2), (i == 14), 1'b0, 1'b1};
         end else begin
            drive(1'b0, 1'b1, 4'hF);
            exp_st = {8'h00, 1'b0, 1'b0, 1'b1};
         end
         total++;
         if (st !== exp_st) begin
            bad++;
            $display("[TB] FAIL valid_toggle cyc%0d st=%b want %b", i, st, exp_st);
         end
      end
      total++;
      if (y !== 32'h76543210) begin
         bad++;
         $display("[TB] FAIL valid_toggle_y y=%h want 76543210", y);
      end
   endtask

   task automatic test_hunt_no_sync();
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, 1'b0, 4'hA);
         total++;
         if ({y, st} !== '0) begin
            bad++;
            $display("[TB] FAIL hunt_no_sync cyc%0d y=%h st=%b want all zero", i, y, st);
         end
      end
   endtask

   task automatic test_early_sync();
      logic [W-1:0] rs [8];
      rs = '{4'h3, 4'h5, 4'h7, 4'h9, 4'hB, 4'hD, 4'hF, 4'h1};
      for (int k = 0; k < 8; k++) begin
         drive(1'b1, k == 0, W'(k + 8));
         exp_st = {8'h01 << k, (k == 7), 1'b0, 1'b1};
         total++;
         if (st !== exp_st) begin
            bad++;
            $display("[TB] FAIL early_sync_pre slot%0d st=%b want %b", k, st, exp_st);
         end
      end
      total++;
      if (y !== 32'hFEDCBA98) begin
         bad++;
         $display("[TB] FAIL early_sync_pre_y y=%h want fedcba98", y);
      end
      for (int k = 0; k < 4; k++) begin
         drive(1'b1, k == 0, 4'hE);
      end
      drive(1'b1, 1'b1, rs[0]);
      total++;
      if ({y, st} !== {32'hFEDCBA98, 8'h01, 1'b0, 1'b1, 1'b1}) begin
         bad++;
         $display("[TB] FAIL early_sync_err y=%h st=%b", y, st);
      end
      for (int k = 1; k < 8; k++) begin
         drive(1'b1, 1'b0, rs[k]);
         exp_st = {8'h01 << k, (k == 7), 1'b0, 1'b1};
         total++;
         if (st !== exp_st) begin
            bad++;
            $display("[TB] FAIL early_sync_resync slot%0d st=%b want %b", k, st, exp_st);
         end
      end
      total++;
      if (y !== 32'h1FDB9753) begin
         bad++;
         $display("[TB] FAIL early_sync_y y=%h want 1fdb9753", y);
      end
   endtask

   task automatic test_missing_sync();
      drive(1'b1, 1'b0, 4'h6);
      total++;
      if ({y, st} !== {32'h1FDB9753, 8'h00, 1'b0, 1'b1, 1'b0}) begin
         bad++;
         $display("[TB] FAIL missing_sync_err y=%h st=%b", y, st);
      end
      drive(1'b1, 1'b0, 4'h6);
      total++;
      if (st !== 11'b0) begin
         bad++;
         $display("[TB] FAIL missing_sync_hunt st=%b want 0", st);
      end
      for (int k = 0; k < 8; k++) begin
         drive(1'b1, k == 0, W'(7 - k));
         exp_st = {8'h01 << k, (k == 7), 1'b0, 1'b1};
         total++;
         if (st !== exp_st) begin
            bad++;
            $display("[TB] FAIL missing_sync_relock slot%0d st=%b want %b", k, st, exp_st);
         end
      end
      total++;
      if (y !== 32'h01234567) begin
         bad++;
         $display("[TB] FAIL missing_sync_y y=%h want 01234567", y);
      end
   endtask

   task automatic test_reset_mid_frame();
      for (int k = 0; k < 5; k++) begin
         drive(1'b1, k == 0, 4'h9);
      end
      #2 rst = 1'b1;
      #1;
      total++;
      if ({y, st} !== '0) begin
         bad++;
         $display("[TB] FAIL reset_mid_frame y=%h st=%b want all zero", y, st);
      end
      @(posedge clk);
      @(posedge clk);
      #1 rst = 1'b0;
      for (int k = 0; k < 8; k++) begin
         drive(1'b1, k == 0, 4'h5);
         total++;
         if (y !== ((k == 7) ? 32'h55555555 : 32'h0)) begin
            bad++;
            $display("[TB] FAIL reset_refill slot%0d y=%h", k, y);
         end
      end
   endtask

   initial begin
      $display("[TB] start");
      test_reset();
      test_full_frame();
      test_valid_toggle();
      test_reset();
      test_hunt_no_sync();
      test_early_sync();
      test_missing_sync();
      test_reset_mid_frame();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
